// File: rtl/morse_symbol_capture_pkg.sv
// Shared constants for the Morse letter capture block: state encodings,
// default timing parameters and symbol codes.
package morse_symbol_capture_pkg;

  localparam int unsigned DASH_MS_DEFAULT = 300;
  localparam int unsigned GAP_MS_DEFAULT  = 700;
  localparam int unsigned MAX_SYM_DEFAULT = 5;

  localparam int unsigned CODE_W = 5;
  localparam int unsigned LEN_W  = 3;
  localparam int unsigned CNT_W  = 10;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_KEY = 3'd1;
  localparam logic [2:0] PRESS    = 3'd2;
  localparam logic [2:0] GAP      = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  function automatic logic classifyPress(input logic [CNT_W-1:0] pressMs,
                                         input int unsigned dashMs);
    return (32'(pressMs) >= dashMs) ? SYM_DASH : SYM_DOT;
  endfunction

endpackage

// File: rtl/morse_symbol_capture_if.sv
// Result handshake between the Morse capture block and its consumer.
interface morse_symbol_capture_if;
  import morse_symbol_capture_pkg::*;

  logic [CODE_W-1:0] code;
  logic [LEN_W-1:0]  code_len;
  logic              timed_out;
  logic              code_valid;
  logic              code_ready;

  modport master (output code, code_len, timed_out, code_valid, input code_ready);
  modport slave  (input code, code_len, timed_out, code_valid, output code_ready);
endinterface

// File: rtl/morse_symbol_capture_ms_duration_counter.sv
// 10-bit millisecond duration counter: clear has priority, increments on
// ms_tick and sticks at all-ones.
module ms_duration_counter
  import morse_symbol_capture_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/morse_symbol_capture.sv
// Captures one Morse letter from a debounced key: classifies presses as
// dots/dashes by duration and closes the letter on a long gap, full code or timeout.
module morse_symbol_capture
  import morse_symbol_capture_pkg::*;
#(
  parameter int unsigned DASH_MS = DASH_MS_DEFAULT,
  parameter int unsigned GAP_MS  = GAP_MS_DEFAULT,
  parameter int unsigned MAX_SYM = MAX_SYM_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic key,
  input  logic ms_tick,
  input  logic timeout,
  output logic timer_en,
  output logic timer_clr,
  output logic busy,
  morse_symbol_capture_if.master res
);

  logic [2:0]       state;
  logic [CNT_W-1:0] msCount;
  logic             cntClr;
  logic             cntInc;
  logic [LEN_W-1:0] nextLen;
  logic             lenFull;
  logic             gapDone;

  ms_duration_counter u_msCounter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cntClr),
    .inc   (cntInc),
    .count (msCount)
  );

  // Counter clears mirror the FSM edges; a coincident timeout suppresses them.
  always_comb begin
    cntClr = 1'b0;
    case (state)
      IDLE:     cntClr = start;
      WAIT_KEY: cntClr = key && !timeout;
      PRESS:    cntClr = !key && !timeout;
      GAP:      cntClr = key && !timeout;
      default:  cntClr = 1'b0;
    endcase
    cntInc  = ms_tick && ((state == PRESS) || (state == GAP));
    nextLen = res.code_len + 1'b1;
    lenFull = (32'(nextLen) >= MAX_SYM);
    gapDone = ms_tick && ((32'(msCount) + 32'd1) >= GAP_MS);
  end

  always_comb begin
    busy           = (state != IDLE);
    timer_en       = (state == WAIT_KEY) || (state == PRESS) || (state == GAP);
    res.code_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      res.code      <= '0;
      res.code_len  <= '0;
      res.timed_out <= 1'b0;
      timer_clr     <= 1'b0;
    end else begin
      timer_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= WAIT_KEY;
            res.code      <= '0;
            res.code_len  <= '0;
            res.timed_out <= 1'b0;
            timer_clr     <= 1'b1;
          end
        end
        WAIT_KEY: begin
          if (timeout) begin
            state         <= DONE;
            res.timed_out <= 1'b1;
          end else if (key) begin
            state <= PRESS;
          end
        end
        PRESS: begin
          if (timeout) begin
            state         <= DONE;
            res.timed_out <= 1'b1;
          end else if (!key) begin
            res.code     <= (res.code << 1) |
                            {{(CODE_W-1){1'b0}}, classifyPress(msCount, DASH_MS)};
            res.code_len <= nextLen;
            state        <= lenFull ? DONE : GAP;
          end
        end
        GAP: begin
          if (timeout) begin
            state         <= DONE;
            res.timed_out <= 1'b1;
          end else if (key) begin
            state <= PRESS;
          end else if (gapDone) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (res.code_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_symbol_capture.sv
// Directed bench for morse_symbol_capture with hand-computed expectations.
module tb_morse_symbol_capture;

  logic clk = 1'b0;
  logic rst, start, key, ms_tick, timeout;
  logic timer_en, timer_clr, busy;
  int   nCompared   = 0;
  int   nMismatched = 0;

  morse_symbol_capture_if resIf ();

  morse_symbol_capture #(
    .DASH_MS (300),
    .GAP_MS  (700),
    .MAX_SYM (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key       (key),
    .ms_tick   (ms_tick),
    .timeout   (timeout),
    .timer_en  (timer_en),
    .timer_clr (timer_clr),
    .busy      (busy),
    .res       (resIf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      ms_tick = 1'b1;
      cyc(1);
      ms_tick = 1'b0;
      cyc(1);
    end
  endtask

  task automatic press(input int ms);
    key = 1'b1;
    cyc(1);
    ticks(ms);
    key = 1'b0;
    cyc(1);
  endtask

  task automatic startLetter();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic accept();
    resIf.code_ready = 1'b1;
    cyc(1);
    resIf.code_ready = 1'b0;
  endtask

  task automatic checkResult(input string tag, input logic [4:0] code,
                             input logic [2:0] len, input logic to);
    check({tag, "_valid"}, 32'(resIf.code_valid), 32'd1);
    check({tag, "_code"}, 32'(resIf.code), 32'(code));
    check({tag, "_len"}, 32'(resIf.code_len), 32'(len));
    check({tag, "_timedout"}, 32'(resIf.timed_out), 32'(to));
    check({tag, "_timeren"}, 32'(timer_en), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key = 1'b0; ms_tick = 1'b0; timeout = 1'b0;
    resIf.code_ready = 1'b0;
    cyc(2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(resIf.code_valid), 32'd0);
    check("rst_timeren", 32'(timer_en), 32'd0);
    check("rst_timerclr", 32'(timer_clr), 32'd0);
    check("rst_len", 32'(resIf.code_len), 32'd0);
    rst = 1'b0;
    key = 1'b1;
    cyc(3);
    check("idle_key_ignored", 32'(busy), 32'd0);
    key = 1'b0;

    // Single dot, letter closed by a 700 ms gap.
    startLetter();
    check("t38_timerclr", 32'(timer_clr), 32'd1);
    check("t38_timeren", 32'(timer_en), 32'd1);
    check("t38_busy", 32'(busy), 32'd1);
    cyc(1);
    check("t38_timerclr_pulse", 32'(timer_clr), 32'd0);
    press(100);
    check("t38_len_after_release", 32'(resIf.code_len), 32'd1);
    check("t38_gap_timeren", 32'(timer_en), 32'd1);
    ticks(699);
    check("t38_not_done_699", 32'(resIf.code_valid), 32'd0);
    ms_tick = 1'b1;
    cyc(1);
    ms_tick = 1'b0;
    checkResult("t38", 5'b00000, 3'd1, 1'b0);
    accept();
    check("t38_accept_valid", 32'(resIf.code_valid), 32'd0);
    check("t38_accept_busy", 32'(busy), 32'd0);

    // Dot, dash (exactly 300 ms), dot (299 ms).
    startLetter();
    press(100);
    ticks(200);
    press(300);
    ticks(200);
    press(299);
    ticks(699);
    check("t39_not_done", 32'(resIf.code_valid), 32'd0);
    ticks(1);
    checkResult("t39", 5'b00010, 3'd3, 1'b0);
    accept();

    // Five dashes: fifth release closes the letter without a gap.
    startLetter();
    repeat (4) begin
      press(400);
      ticks(100);
    end
    check("t40_len4", 32'(resIf.code_len), 32'd4);
    check("t40_not_done", 32'(resIf.code_valid), 32'd0);
    press(400);
    checkResult("t40", 5'b11111, 3'd5, 1'b0);
    accept();

    // Timeout with no key; result held while consumer stalls.
    startLetter();
    cyc(3);
    timeout = 1'b1;
    cyc(1);
    timeout = 1'b0;
    checkResult("t41", 5'b00000, 3'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      key   = i[0];
      start = 1'b1;
      cyc(1);
      check("t41_hold_valid", 32'(resIf.code_valid), 32'd1);
      check("t41_hold_len", 32'(resIf.code_len), 32'd0);
      check("t41_hold_timedout", 32'(resIf.timed_out), 32'd1);
    end
    key = 1'b0; start = 1'b0;
    accept();

    // Timeout coincident with release discards the press.
    startLetter();
    key = 1'b1;
    cyc(1);
    ticks(50);
    key = 1'b0;
    timeout = 1'b1;
    cyc(1);
    timeout = 1'b0;
    checkResult("t42", 5'b00000, 3'd0, 1'b1);
    accept();

    // Timeout coincident with a new press in GAP.
    startLetter();
    press(400);
    key = 1'b1;
    timeout = 1'b1;
    cyc(1);
    timeout = 1'b0;
    key = 1'b0;
    checkResult("t26_gap", 5'b00001, 3'd1, 1'b1);
    accept();

    // Reset in the middle of a press.
    startLetter();
    press(400);
    key = 1'b1;
    cyc(1);
    ticks(20);
    check("t43_pre_len", 32'(resIf.code_len), 32'd1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    key = 1'b0;
    check("t43_busy", 32'(busy), 32'd0);
    check("t43_timeren", 32'(timer_en), 32'd0);
    check("t43_timerclr", 32'(timer_clr), 32'd0);
    check("t43_valid", 32'(resIf.code_valid), 32'd0);
    check("t43_code", 32'(resIf.code), 32'd0);
    check("t43_len", 32'(resIf.code_len), 32'd0);
    check("t43_timedout", 32'(resIf.timed_out), 32'd0);

    // start while busy must not restart the letter.
    startLetter();
    press(400);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("t30_no_clr", 32'(timer_clr), 32'd0);
    check("t30_len_kept", 32'(resIf.code_len), 32'd1);
    check("t30_busy", 32'(busy), 32'd1);
    ticks(700);
    checkResult("t30", 5'b00001, 3'd1, 1'b0);
    accept();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
